// File: rtl/noc_output_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_output_port_arbiter_if
// Bundles the signals between the input-port requesters and the downstream
// link of one router output port.
//   req_valid/req_head/req_tail  per-requester flit qualifiers
//   req_vc                       requested VC per requester, VCW bits each
//   req_ready                    per-requester accept
//   out_valid/out_sel/out_vc     output link strobe, crossbar select, VC tag
//   credit_return                per-VC slot-freed pulse from downstream
//   credit_count                 per-VC credits, CW bits each
//   busy/credit_overflow         port locked / credit returned at full count
// Modports: master = requesters + link side, slave = arbiter.
// ---------------------------------------------------------------------------
interface noc_output_port_arbiter_if #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned VC_DEPTH = 4
);
  localparam int unsigned VCW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned SELW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW   = $clog2(VC_DEPTH + 1);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_head;
  logic [NUM_REQ-1:0]     req_tail;
  logic [NUM_REQ*VCW-1:0] req_vc;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   out_valid;
  logic [SELW-1:0]        out_sel;
  logic [VCW-1:0]         out_vc;
  logic [NUM_VC-1:0]      credit_return;
  logic [NUM_VC*CW-1:0]   credit_count;
  logic                   busy;
  logic                   credit_overflow;

  modport master (
    output req_valid, req_head, req_tail, req_vc, credit_return,
    input  req_ready, out_valid, out_sel, out_vc, credit_count, busy, credit_overflow
  );

  modport slave (
    input  req_valid, req_head, req_tail, req_vc, credit_return,
    output req_ready, out_valid, out_sel, out_vc, credit_count, busy, credit_overflow
  );
endinterface

// File: rtl/noc_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// noc_output_port_arbiter
// Wormhole switch allocator for one mesh router output port. Round-robin
// arbitration among head flits, port locked from head to tail, per-VC
// downstream credit tracking with owner stall on an empty VC.
//   noc_clk   clock
//   noc_rst   synchronous reset, active-high
//   bus       noc_output_port_arbiter_if.slave (requests, link, credits)
// ---------------------------------------------------------------------------
module noc_output_port_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned VC_DEPTH = 4
) (
  input  logic                        noc_clk,
  input  logic                        noc_rst,
  noc_output_port_arbiter_if.slave    bus
);
  localparam int unsigned VCW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned SELW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW   = $clog2(VC_DEPTH + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [SELW-1:0] owner, owner_nxt;
  logic [VCW-1:0]  vc_q, vc_nxt;
  logic [SELW-1:0] last_grant, last_grant_nxt;
  logic [CW-1:0]   credit     [NUM_VC];
  logic [CW-1:0]   credit_nxt [NUM_VC];
  logic            ovf_q, ovf_nxt;

  logic [NUM_VC-1:0]  vc_nz;
  logic [NUM_REQ-1:0] eligible;
  logic               owner_has_credit;
  logic               xfer;
  logic               grant_found;
  logic [SELW-1:0]    winner;
  logic [SELW-1:0]    cand;

  // Per-VC non-empty flags and eligibility of head flits
  always_comb begin
    vc_nz            = '0;
    eligible         = '0;
    owner_has_credit = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_nz[v] = (credit[v] != '0);
      if (vc_q == VCW'(v)) owner_has_credit = vc_nz[v];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if ((bus.req_vc[i*VCW +: VCW] == VCW'(v)) && vc_nz[v])
          eligible[i] = bus.req_valid[i] & bus.req_head[i];
      end
    end
  end

  // Round-robin search starting just after the previous winner
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    cand        = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == SELW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        winner      = cand;
      end
    end
  end

  // Ready depends only on registers (plus reset, so nothing is taken in the reset cycle)
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = !noc_rst && (state == LOCKED) && (owner == SELW'(i)) && owner_has_credit;
    end
    xfer = !noc_rst && (state == LOCKED) && owner_has_credit && bus.req_valid[owner];
  end

  // Next state, lock bookkeeping and credit accounting
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    vc_nxt         = vc_q;
    last_grant_nxt = last_grant;
    ovf_nxt        = 1'b0;
    for (int v = 0; v < NUM_VC; v++) credit_nxt[v] = credit[v];

    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = LOCKED;
          owner_nxt = winner;
          vc_nxt    = bus.req_vc[winner*VCW +: VCW];
        end
      end
      LOCKED: begin
        if (xfer && bus.req_tail[owner]) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A same-cycle send and return on one VC cancel out
    for (int v = 0; v < NUM_VC; v++) begin
      if (xfer && (vc_q == VCW'(v)) && !bus.credit_return[v]) begin
        credit_nxt[v] = credit[v] - 1'b1;
      end else if (bus.credit_return[v] && !(xfer && (vc_q == VCW'(v)))) begin
        if (credit[v] == CW'(VC_DEPTH)) ovf_nxt = 1'b1;
        else                            credit_nxt[v] = credit[v] + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state      <= IDLE;
      owner      <= '0;
      vc_q       <= '0;
      last_grant <= SELW'(NUM_REQ - 1);
      ovf_q      <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= CW'(VC_DEPTH);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      vc_q       <= vc_nxt;
      last_grant <= last_grant_nxt;
      ovf_q      <= ovf_nxt;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= credit_nxt[v];
    end
  end

  // Output mapping
  always_comb begin
    bus.credit_count = '0;
    for (int v = 0; v < NUM_VC; v++) bus.credit_count[v*CW +: CW] = credit[v];
  end

  assign bus.out_valid       = xfer;
  assign bus.out_sel         = owner;
  assign bus.out_vc          = vc_q;
  assign bus.busy            = (state == LOCKED);
  assign bus.credit_overflow = ovf_q;
endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_output_port_arbiter
// Directed bench: a per-cycle vector table (arbitration order, tail release,
// credit cancel/overflow, mid-packet reset) plus hand-written sequences for
// alternating multi-flit packets, credit starvation and single-flit rotation.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
// ---------------------------------------------------------------------------
module tb_noc_output_port_arbiter;
  localparam int unsigned NUM_REQ  = 5;
  localparam int unsigned NUM_VC   = 2;
  localparam int unsigned VC_DEPTH = 4;

  logic noc_clk = 1'b0;
  logic noc_rst = 1'b1;
  always #5 noc_clk = ~noc_clk;

  noc_output_port_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH)) bus ();

  noc_output_port_arbiter #(.NUM_REQ(NUM_REQ), .NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH)) dut (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [4:0] v, h, t, vc;
    logic [1:0] cr;
    logic       chk;
    logic [4:0] rdy;
    logic       ov;
    logic [2:0] sel;
    logic       ovc;
    logic       busy;
    logic [2:0] c0, c1;
    logic       ovf;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [4:0] v, h, t, vc, input logic [1:0] cr,
                              input logic chk, input logic [4:0] rdy, input logic ov,
                              input logic [2:0] sel, input logic ovc, input logic busy,
                              input logic [2:0] c0, c1, input logic ovf);
    vec_t r;
    r.rst = rst; r.v = v; r.h = h; r.t = t; r.vc = vc; r.cr = cr; r.chk = chk;
    r.rdy = rdy; r.ov = ov; r.sel = sel; r.ovc = ovc; r.busy = busy;
    r.c0 = c0; r.c1 = c1; r.ovf = ovf;
    return r;
  endfunction

  function automatic logic [31:0] obs();
    return {14'b0, bus.req_ready, bus.out_valid, bus.out_sel, bus.out_vc, bus.busy,
            bus.credit_count[2:0], bus.credit_count[5:3], bus.credit_overflow};
  endfunction

  function automatic logic [31:0] expk(input vec_t e);
    return {14'b0, e.rdy, e.ov, e.sel, e.ovc, e.busy, e.c0, e.c1, e.ovf};
  endfunction

  task automatic drive(input logic rst, input logic [4:0] v, h, t, vc, input logic [1:0] cr);
    @(negedge noc_clk);
    noc_rst           = rst;
    bus.req_valid     = v;
    bus.req_head      = h;
    bus.req_tail      = t;
    bus.req_vc        = vc;
    bus.credit_return = cr;
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    drive(1'b1, '0, '0, '0, '0, '0);
    drive(1'b1, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [4:0] pend;
    logic [4:0] onehot;
    logic [4:0] v, h, t;
    int fi1, fi3, fi, o;

    bus.req_valid = '0; bus.req_head = '0; bus.req_tail = '0;
    bus.req_vc = '0;    bus.credit_return = '0;

    //            rst  valid     head      tail      vc        cr    chk | ready    ov sel ovc busy c0 c1 ovf
    tbl[0]  = mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 0, 0, 0, 0, 4, 4, 0);
    tbl[1]  = mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 0, 0, 0, 4, 4, 0);
    tbl[2]  = mk(0, 5'b00101, 5'b00101, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 0, 0, 0, 4, 4, 0);
    tbl[3]  = mk(0, 5'b00101, 5'b00101, 5'b00000, 5'b00000, 2'b00, 1, 5'b00001, 1, 0, 0, 1, 4, 4, 0);
    tbl[4]  = mk(0, 5'b00101, 5'b00100, 5'b00001, 5'b00000, 2'b00, 1, 5'b00001, 1, 0, 0, 1, 3, 4, 0);
    tbl[5]  = mk(0, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 2'b00, 1, 5'b00000, 0, 0, 0, 0, 2, 4, 0);
    tbl[6]  = mk(0, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 2'b00, 1, 5'b00100, 1, 2, 1, 1, 2, 4, 0);
    tbl[7]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 2'b00, 1, 5'b00000, 0, 2, 1, 0, 2, 3, 0);
    tbl[8]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 2'b01, 1, 5'b00010, 1, 1, 0, 1, 2, 3, 0);
    tbl[9]  = mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 1, 5'b00000, 0, 1, 0, 0, 2, 3, 0);
    tbl[10] = mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 1, 5'b00000, 0, 1, 0, 0, 3, 4, 0);
    tbl[11] = mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 1, 0, 0, 4, 4, 1);
    tbl[12] = mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 1, 0, 0, 4, 4, 0);
    tbl[13] = mk(0, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 1, 0, 0, 4, 4, 0);
    tbl[14] = mk(0, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b00, 1, 5'b01000, 1, 3, 0, 1, 4, 4, 0);
    tbl[15] = mk(0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b01000, 1, 3, 0, 1, 3, 4, 0);
    tbl[16] = mk(0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b01000, 1, 3, 0, 1, 2, 4, 0);
    tbl[17] = mk(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 3, 0, 1, 1, 4, 0);
    tbl[18] = mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 0, 0, 0, 4, 4, 0);
    tbl[19] = mk(0, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 2'b00, 1, 5'b00000, 0, 0, 0, 0, 4, 4, 0);
    tbl[20] = mk(0, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 2'b00, 1, 5'b00001, 1, 0, 0, 1, 4, 4, 0);

    for (int n = 0; n < NV; n++) begin
      drive(tbl[n].rst, tbl[n].v, tbl[n].h, tbl[n].t, tbl[n].vc, tbl[n].cr);
      if (tbl[n].chk) check($sformatf("vec%0d", n), obs(), expk(tbl[n]));
    end

    // Requesters 1 and 3, continuous 3-flit packets on vc0; credits returned as flits leave
    reset_dut();
    fi1 = 0; fi3 = 0;
    for (int p = 0; p < 4; p++) begin
      o = (p % 2 == 0) ? 1 : 3;
      v = 5'b01010;
      h = '0; h[1] = (fi1 == 0); h[3] = (fi3 == 0);
      t = '0; t[1] = (fi1 == 2); t[3] = (fi3 == 2);
      drive(1'b0, v, h, t, 5'b00000, 2'b00);
      check($sformatf("alt_gap_busy%0d", p), 32'(bus.busy), 32'd0);
      check($sformatf("alt_gap_oval%0d", p), 32'(bus.out_valid), 32'd0);
      for (int f = 0; f < 3; f++) begin
        h = '0; h[1] = (fi1 == 0); h[3] = (fi3 == 0);
        t = '0; t[1] = (fi1 == 2); t[3] = (fi3 == 2);
        drive(1'b0, v, h, t, 5'b00000, 2'b01);
        onehot = '0; onehot[o] = 1'b1;
        check($sformatf("alt_p%0d_f%0d_sel", p, f), 32'(bus.out_sel), 32'(o));
        check($sformatf("alt_p%0d_f%0d_rdy", p, f), 32'(bus.req_ready), 32'(onehot));
        check($sformatf("alt_p%0d_f%0d_oval", p, f), 32'(bus.out_valid), 32'd1);
        if (o == 1) fi1 = (fi1 + 1) % 3;
        else        fi3 = (fi3 + 1) % 3;
      end
    end
    drive(1'b0, '0, '0, '0, '0, 2'b00);
    check("alt_end_cnt0", 32'(bus.credit_count[2:0]), 32'd4);
    check("alt_end_ovf", 32'(bus.credit_overflow), 32'd0);

    // Six-flit packet on vc1 with only four credits, then one credit returned
    reset_dut();
    fi = 0;
    drive(1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 2'b00);
    check("starve_idle_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'b00001, 5'(fi == 0), 5'b00000, 5'b00001, 2'b00);
      check($sformatf("starve_flit%0d_rdy", k), 32'(bus.req_ready), 32'b00001);
      check($sformatf("starve_flit%0d_oval", k), 32'(bus.out_valid), 32'd1);
      fi++;
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2'b00);
      check($sformatf("starve_hold%0d_rdy", k), 32'(bus.req_ready), 32'd0);
      check($sformatf("starve_hold%0d_cnt1", k), 32'(bus.credit_count[5:3]), 32'd0);
      check($sformatf("starve_hold%0d_busy", k), 32'(bus.busy), 32'd1);
    end
    drive(1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2'b10);
    check("starve_ret_rdy", 32'(bus.req_ready), 32'd0);
    drive(1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2'b00);
    check("starve_one_rdy", 32'(bus.req_ready), 32'b00001);
    check("starve_one_oval", 32'(bus.out_valid), 32'd1);
    check("starve_one_cnt1", 32'(bus.credit_count[5:3]), 32'd1);
    drive(1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2'b00);
    check("starve_after_rdy", 32'(bus.req_ready), 32'd0);
    check("starve_after_cnt1", 32'(bus.credit_count[5:3]), 32'd0);
    check("starve_cnt0", 32'(bus.credit_count[2:0]), 32'd4);

    // Single-flit packets from all five ports: 0..4, two cycles each
    reset_dut();
    pend = 5'b11111;
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, pend, pend, pend, 5'b00000, 2'b00);
      check($sformatf("single%0d_idle_busy", g), 32'(bus.busy), 32'd0);
      check($sformatf("single%0d_idle_rdy", g), 32'(bus.req_ready), 32'd0);
      drive(1'b0, pend, pend, pend, 5'b00000, 2'b01);
      onehot = '0; onehot[g] = 1'b1;
      check($sformatf("single%0d_busy", g), 32'(bus.busy), 32'd1);
      check($sformatf("single%0d_sel", g), 32'(bus.out_sel), 32'(g));
      check($sformatf("single%0d_rdy", g), 32'(bus.req_ready), 32'(onehot));
      pend[g] = 1'b0;
    end
    drive(1'b0, '0, '0, '0, '0, 2'b00);
    check("single_end_busy", 32'(bus.busy), 32'd0);
    check("single_end_cnt", 32'(bus.credit_count), 32'({3'd4, 3'd4}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
